// File: rtl/writeback.sv
// Write-back stage: registers the retiring instruction, selects ALU or extended load data,
// and drives the register file write port. RISKY_WB_RETIRE_CNT_EN adds a retired-instruction counter.
module writeback #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic [4:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic            we_o,
  output logic [4:0]      sel_rd_o,
  output logic [XLEN-1:0] rd_o,
  output logic            illegal_o
`ifdef RISKY_WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt_o
`endif
);

  // Handshake: valid_i qualifies the stage-4 fields; stall_i=1 freezes the register and
  // suppresses retirement, so the held instruction retires once, in the first unstalled cycle.

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_LOAD    = 2'd1,
    CLS_NONE    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } wb_class_e;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // Pipeline register
  logic            r_valid;
  logic [4:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_mem_data;
  logic [1:0]      r_addr_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_addr_lo    <= '0;
    end else if (!stall_i) begin
      r_valid      <= valid_i;
      r_opcode     <= opcode_i;
      r_funct3     <= funct3_i;
      r_rd         <= rd_i;
      r_alu_result <= alu_result_i;
      r_mem_data   <= mem_data_i;
      r_addr_lo    <= alu_result_i[1:0];
    end
  end

  wb_class_e wb_class;

  always_comb begin
    wb_class = CLS_ILLEGAL;
    case (r_opcode)
      OPC_LOAD:                                              wb_class = CLS_LOAD;
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: wb_class = CLS_ALU;
      OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM:       wb_class = CLS_NONE;
      default:                                               wb_class = CLS_ILLEGAL;
    endcase
  end

  // Load extraction from the aligned word
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic            load_ok;

  always_comb begin
    load_byte = r_mem_data[7:0];
    case (r_addr_lo)
      2'd0:    load_byte = r_mem_data[7:0];
      2'd1:    load_byte = r_mem_data[15:8];
      2'd2:    load_byte = r_mem_data[23:16];
      default: load_byte = r_mem_data[31:24];
    endcase
    // Half select ignores addr_lo[0]; misaligned halves are not split here.
    load_half = r_addr_lo[1] ? r_mem_data[31:16] : r_mem_data[15:0];
  end

  always_comb begin
    load_data = '0;
    load_ok   = 1'b1;
    case (r_funct3)
      F3_LB:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
      F3_LW:   load_data = r_mem_data;
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_ok   = 1'b0;
    endcase
  end

  logic            retire;
  logic            writes;
  logic            illegal;
  logic [XLEN-1:0] wb_data;

  always_comb begin
    retire  = r_valid & ~stall_i;
    writes  = (wb_class == CLS_ALU) | ((wb_class == CLS_LOAD) & load_ok);
    illegal = (wb_class == CLS_ILLEGAL) | ((wb_class == CLS_LOAD) & ~load_ok);
    wb_data = (wb_class == CLS_LOAD) ? load_data : r_alu_result;
  end

  // x0 destinations retire normally but never assert the write enable.
  assign we_o      = retire & writes & (r_rd != 5'd0);
  assign illegal_o = retire & illegal;
  assign sel_rd_o  = r_valid ? r_rd : 5'd0;
  assign rd_o      = r_valid ? wb_data : '0;

`ifdef RISKY_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

  assign retire_cnt_o = retire_cnt;
`endif

endmodule

// File: tb/tb_writeback.sv
// Randomized and directed bench for writeback against a field-level reference model.
// Build with RISKY_WB_RETIRE_CNT_EN defined to also cover the retire counter (CNT_W=4 here).
module tb_writeback;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  typedef struct {
    bit        v;
    bit [4:0]  op;
    bit [2:0]  f3;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit [31:0] mem;
  } ins_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic            stall_i;
  logic [4:0]      opcode_i;
  logic [2:0]      funct3_i;
  logic [4:0]      rd_i;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] mem_data_i;
  logic            we_o;
  logic [4:0]      sel_rd_o;
  logic [XLEN-1:0] rd_o;
  logic            illegal_o;
`ifdef RISKY_WB_RETIRE_CNT_EN
  logic [CW-1:0]   retire_cnt_o;
`endif

  writeback #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .stall_i      (stall_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .rd_i         (rd_i),
    .alu_result_i (alu_result_i),
    .mem_data_i   (mem_data_i),
    .we_o         (we_o),
    .sel_rd_o     (sel_rd_o),
    .rd_o         (rd_o),
    .illegal_o    (illegal_o)
`ifdef RISKY_WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o (retire_cnt_o)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ins_t model_reg;
  int   cnt_model;
  logic [36:0] exp_q[$];
  bit          last_we;
  bit          last_ill;
  bit [31:0]   last_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decode straight from the instruction-set rules.
  function automatic void model_wb(input ins_t i, input bit stall,
                                   output bit we, output bit ill, output bit [31:0] data);
    bit writes;
    bit illegal;
    int b;
    int h;
    writes  = 0;
    illegal = 0;
    data    = i.alu;
    case (i.op)
      5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11011, 5'b11001: writes = 1;
      5'b01000, 5'b11000, 5'b00011, 5'b11100: writes = 0;
      5'b00000: begin
        b = int'((i.mem >> (8 * (i.alu % 4))) & 32'hFF);
        h = int'((i.mem >> (16 * ((i.alu / 2) % 2))) & 32'hFFFF);
        writes = 1;
        case (i.f3)
          3'd0: data = (b >= 128) ? 32'(b - 256) : 32'(b);
          3'd1: data = (h >= 32768) ? 32'(h - 65536) : 32'(h);
          3'd2: data = i.mem;
          3'd4: data = 32'(b);
          3'd5: data = 32'(h);
          default: begin writes = 0; illegal = 1; end
        endcase
      end
      default: illegal = 1;
    endcase
    we  = i.v && !stall && writes && (i.rd != 0);
    ill = i.v && !stall && illegal;
  endfunction

  // Driver: present one input set for a cycle, check outputs mid-cycle, then advance the model.
  task automatic step(input ins_t i, input bit stall);
    bit        e_we;
    bit        e_ill;
    bit [31:0] e_data;
    valid_i      = i.v;
    opcode_i     = i.op;
    funct3_i     = i.f3;
    rd_i         = i.rd;
    alu_result_i = i.alu;
    mem_data_i   = i.mem;
    stall_i      = stall;
    @(negedge clk);
    model_wb(model_reg, stall, e_we, e_ill, e_data);
    if (e_we) exp_q.push_back({model_reg.rd, e_data});
    check("we", {63'd0, we_o}, {63'd0, e_we});
    check("illegal", {63'd0, illegal_o}, {63'd0, e_ill});
    if (we_o === 1'b1) begin
      if (exp_q.size() > 0) check("wb_port", {27'd0, sel_rd_o, rd_o}, {27'd0, exp_q.pop_front()});
      else check("wb_unexpected", {63'd0, we_o}, 64'd0);
    end
`ifdef RISKY_WB_RETIRE_CNT_EN
    check("retire_cnt", {60'd0, retire_cnt_o}, 64'(cnt_model));
`endif
    last_we   = we_o;
    last_ill  = illegal_o;
    last_data = rd_o;
    @(posedge clk);
    if (model_reg.v && !stall) cnt_model = (cnt_model + 1) % (1 << CW);
    if (!stall) model_reg = i;
    #1;
  endtask

  function automatic ins_t mk(input bit [4:0] op, input bit [2:0] f3, input bit [4:0] rd,
                              input bit [31:0] alu, input bit [31:0] mem);
    ins_t i;
    i.v = 1; i.op = op; i.f3 = f3; i.rd = rd; i.alu = alu; i.mem = mem;
    return i;
  endfunction

  function automatic ins_t bubble();
    ins_t i;
    i.v = 0; i.op = 0; i.f3 = 0; i.rd = 0; i.alu = 0; i.mem = 0;
    return i;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, {63'd0, we_o}, 64'd0);
    check({tag, "_illegal"}, {63'd0, illegal_o}, 64'd0);
    check({tag, "_sel_rd"}, {59'd0, sel_rd_o}, 64'd0);
    check({tag, "_rd"}, {32'd0, rd_o}, 64'd0);
`ifdef RISKY_WB_RETIRE_CNT_EN
    check({tag, "_cnt"}, {60'd0, retire_cnt_o}, 64'd0);
`endif
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    valid_i = 1'b0;
    stall_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reg = bubble();
    cnt_model = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  localparam bit [31:0] MEMW = 32'h80FF_7F81;

  initial begin
    bit [4:0] ops[14];
    ins_t     r;
    ops = '{5'b00000, 5'b00100, 5'b01100, 5'b01101, 5'b00101, 5'b11011, 5'b11001,
            5'b01000, 5'b11000, 5'b00011, 5'b11100, 5'b11111, 5'b00010, 5'b01010};

    rst = 1'b1; valid_i = 0; stall_i = 0; opcode_i = 0; funct3_i = 0; rd_i = 0;
    alu_result_i = 0; mem_data_i = 0;
    model_reg = bubble();
    cnt_model = 0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // OP write, one cycle only
    step(mk(5'b01100, 0, 5, 32'h0000_1234, 0), 0);
    step(bubble(), 0);
    check("op_we", {63'd0, last_we}, 64'd1);
    check("op_data", {32'd0, last_data}, 64'h1234);
    step(bubble(), 0);
    check("op_once", {63'd0, last_we}, 64'd0);

    // Load variants
    step(mk(5'b00000, 3'd0, 7, 32'h100, MEMW), 0);
    step(mk(5'b00000, 3'd4, 7, 32'h102, MEMW), 0);
    check("lb", {32'd0, last_data}, 64'hFFFF_FF81);
    step(mk(5'b00000, 3'd1, 7, 32'h102, MEMW), 0);
    check("lbu", {32'd0, last_data}, 64'h0000_00FF);
    step(mk(5'b00000, 3'd5, 7, 32'h100, MEMW), 0);
    check("lh", {32'd0, last_data}, 64'hFFFF_80FF);
    step(mk(5'b00000, 3'd2, 7, 32'h104, MEMW), 0);
    check("lhu", {32'd0, last_data}, 64'h0000_7F81);
    step(mk(5'b01100, 0, 0, 32'h55, 0), 0);
    check("lw", {32'd0, last_data}, 64'h80FF_7F81);
    step(mk(5'b01000, 0, 9, 32'h66, 0), 0);
    check("x0_no_we", {63'd0, last_we}, 64'd0);
    step(mk(5'b11111, 0, 9, 32'h77, 0), 0);
    check("store_no_we", {63'd0, last_we}, 64'd0);
    step(mk(5'b00000, 3'd6, 9, 32'h0, MEMW), 0);
    check("illegal_op", {63'd0, last_ill}, 64'd1);
    step(bubble(), 0);
    check("illegal_f3", {63'd0, last_ill}, 64'd1);

    // Stall sequence
    step(mk(5'b01100, 0, 3, 32'hABCD, 0), 0);
    repeat (3) step(bubble(), 1);
    step(bubble(), 0);
    check("stall_release_we", {63'd0, last_we}, 64'd1);
    step(bubble(), 0);
    check("stall_once", {63'd0, last_we}, 64'd0);

    // Async reset while a load is held
    step(mk(5'b00000, 3'd2, 8, 32'h0, MEMW), 0);
    stall_i = 1'b1;
    apply_reset();
    step(bubble(), 0);
    check("no_write_after_rst", {63'd0, last_we}, 64'd0);

    // Counter wrap: 17 retirements on a 4-bit counter
    repeat (17) step(mk(5'b01000, 0, 1, 0, 0), 0);
    step(bubble(), 0);
`ifdef RISKY_WB_RETIRE_CNT_EN
    check("cnt_wrap", {60'd0, retire_cnt_o}, 64'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r.v   = ($urandom_range(0, 9) != 0);
      r.op  = ops[$urandom_range(0, 13)];
      r.f3  = 3'($urandom_range(0, 7));
      r.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.alu = $urandom;
      r.mem = $urandom;
      step(r, $urandom_range(0, 3) == 0);
    end
    step(bubble(), 0);
    step(bubble(), 0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
